// File: rtl/sha256_round_core_if.sv
// sha256_round_core_if
//   Bundles the control, W_t stream and result signals of sha256_round_core.
//   master : block sequencer / scheduler side (drives start, new_msg, h_in,
//            msg_block, w_valid, w_data; observes the rest)
//   slave  : the compression engine
//   Signals:
//     start, new_msg    - begin a compression; new_msg selects IV and clears Block
//     h_in[255:0]       - current digest H0..H7 (H0 in [255:224])
//     msg_block[511:0]  - M0..M15 (M0 in [511:480]), internal-schedule builds only
//     w_valid, w_data   - W_t offered by the scheduler
//     w_ready           - engine accepts W_t this cycle
//     busy, done        - compression in progress / one-cycle completion pulse
//     work_out[255:0]   - working variables a..h (a in [255:224])
//     Block[1:0]        - block sequencing code for the hash-word registers
interface sha256_round_core_if;
  logic         start;
  logic         new_msg;
  logic [255:0] h_in;
  logic [511:0] msg_block;
  logic         w_valid;
  logic [31:0]  w_data;
  logic         w_ready;
  logic         busy;
  logic         done;
  logic [255:0] work_out;
  logic [1:0]   Block;

  modport master (
    output start, new_msg, h_in, msg_block, w_valid, w_data,
    input  w_ready, busy, done, work_out, Block
  );

  modport slave (
    input  start, new_msg, h_in, msg_block, w_valid, w_data,
    output w_ready, busy, done, work_out, Block
  );
endinterface

// File: rtl/sha256_round_core.sv
// sha256_round_core
//   Runs the 64 SHA-256 rounds on one 512-bit block and presents the final
//   working variables a..h. The digest accumulation (H + a..h) is done by the
//   downstream hash-word registers, which decode the Block sequencing code.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - sha256_round_core_if.slave (control, W_t stream, results)
//   Build option:
//     SHA_W_INTERNAL_EN - when defined, W_t is generated internally from
//                         msg_block by a 16-word sliding window; the W_t
//                         handshake is unused (w_ready held 0).
//
//   state   | meaning
//   S_IDLE  | waiting for start; a..h and Block hold
//   S_ROUND | one round per accepted W_t beat, round 0..63
//   S_DONE  | done pulse; Block advances 1<->2
module sha256_round_core (
  input  logic clk,
  input  logic rst_n,
  sha256_round_core_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] f_bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] f_bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_round;
  logic [31:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [1:0]  r_block;
  logic        w_beat;
  logic        w_ready_int;
  logic [31:0] w_wt, w_t1, w_t2;

`ifdef SHA_W_INTERNAL_EN
  function automatic logic [31:0] f_ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] f_ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // r_win[0] is W_t; r_win[15] is W_{t+15}. Each round shifts in W_{t+16}.
  logic [31:0] r_win [16];
  logic [31:0] w_win_nxt;
  logic        w_unused_stream;

  assign w_unused_stream = bus.w_valid ^ (^bus.w_data);
  assign w_ready_int     = 1'b0;
  assign w_beat          = (r_state == S_ROUND);
  assign w_wt            = r_win[0];
  assign w_win_nxt       = f_ssig1(r_win[14]) + r_win[9] + f_ssig0(r_win[1]) + r_win[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      for (int i = 0; i < 16; i++) r_win[i] <= bus.msg_block[511 - 32*i -: 32];
    end else if (w_beat) begin
      for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
      r_win[15] <= w_win_nxt;
    end
  end
`else
  logic w_unused_msg;

  assign w_unused_msg = ^bus.msg_block;
  assign w_ready_int  = (r_state == S_ROUND);
  assign w_beat       = bus.w_valid && w_ready_int;
  assign w_wt         = bus.w_data;
`endif

  assign w_t1 = r_h + f_bsig1(r_e) + ((r_e & r_f) ^ (~r_e & r_g)) + K_ROM[r_round] + w_wt;
  assign w_t2 = f_bsig0(r_a) + ((r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_ROUND;
      S_ROUND: if (w_beat && r_round == 6'd63) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.w_ready = 1'b0;
    case (r_state)
      S_ROUND: begin
        bus.busy    = 1'b1;
        bus.w_ready = w_ready_int;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_round <= '0;
      {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= '0;
      r_block <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_round <= '0;
          {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= bus.new_msg ? IV : bus.h_in;
          if (bus.new_msg) r_block <= 2'd0;
        end
        S_ROUND: if (w_beat) begin
          r_h     <= r_g;
          r_g     <= r_f;
          r_f     <= r_e;
          r_e     <= r_d + w_t1;
          r_d     <= r_c;
          r_c     <= r_b;
          r_b     <= r_a;
          r_a     <= w_t1 + w_t2;
          r_round <= r_round + 6'd1;
        end
        // Block 0 (fresh IV) and 2 both advance to 1; only 1 advances to 2.
        S_DONE: r_block <= (r_block == 2'd1) ? 2'd2 : 2'd1;
        default: ;
      endcase
    end
  end

  assign bus.work_out = {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h};
  assign bus.Block    = r_block;
endmodule

// File: tb/tb_sha256_round_core.sv
module tb_sha256_round_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_round_core_if bus();

  sha256_round_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef SHA_W_INTERNAL_EN
  localparam bit INT_W = 1'b1;
`else
  localparam bit INT_W = 1'b0;
`endif

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  int checks = 0;
  int failures = 0;

  logic [31:0]  tb_m [16];
  logic [31:0]  tb_w [64];
  logic [1:0]   exp_block;
  int           r_lat, r_beats, r_stalls;
  logic [255:0] r_res;
  logic [255:0] abc_res;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_schedule();
    for (int i = 0; i < 64; i++) begin
      if (i < 16) tb_w[i] = tb_m[i];
      else tb_w[i] = (rotr(tb_w[i-2], 17) ^ rotr(tb_w[i-2], 19) ^ (tb_w[i-2] >> 10))
                   + tb_w[i-7]
                   + (rotr(tb_w[i-15], 7) ^ rotr(tb_w[i-15], 18) ^ (tb_w[i-15] >> 3))
                   + tb_w[i-16];
    end
  endtask

  // Straight textbook compression over tb_w; v[0..7] = a..h.
  function automatic logic [255:0] ref_compress(input logic [255:0] init);
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = init[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + tb_w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = v[i];
    return r;
  endfunction

  task automatic random_msg();
    for (int i = 0; i < 16; i++) tb_m[i] = $urandom();
    build_schedule();
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // mode 0: w_valid held high; 1: 5-cycle gap after 11 beats; 2: random gaps.
  // pulse_at / abort_at are cycle counts after the start edge (-1 = unused).
  task automatic run_block(input bit nm, input logic [255:0] hin, input int mode,
                           input int pulse_at, input int abort_at);
    int cyc, gap;
    bit hs, stalling, got_done, busy_ok, wr_ok;
    @(negedge clk);
    bus.start = 1'b1;
    bus.new_msg = nm;
    bus.h_in = hin;
    for (int i = 0; i < 16; i++) bus.msg_block[511 - 32*i -: 32] = tb_m[i];
    @(posedge clk);
    #1 bus.start = 1'b0;
    if (nm) exp_block = 2'd0;
    check("block_after_start", bus.Block, exp_block);
    cyc = 0; gap = 0; r_beats = 0; r_stalls = 0;
    got_done = 0; busy_ok = 1; wr_ok = 1;
    while (!got_done && cyc < 400) begin
      stalling = 1'b0;
      if (r_beats < 64) begin
        if (mode == 1) stalling = (r_beats == 11 && gap < 5);
        else if (mode == 2) stalling = ($urandom_range(0, 3) == 0);
      end
      bus.w_valid = !stalling;
      if (r_beats < 64) bus.w_data = tb_w[r_beats];
      else bus.w_data = $urandom();
      if (pulse_at == cyc) bus.start = 1'b1;
      @(negedge clk);
      hs = bus.w_valid && bus.w_ready;
      @(posedge clk);
      cyc++;
      if (hs) r_beats++;
      if (stalling) begin r_stalls++; gap++; end
      #1 bus.start = 1'b0;
      if (cyc == abort_at) return;
      if (bus.done === 1'b1) begin
        got_done = 1;
        r_res = bus.work_out;
      end else begin
        if (bus.busy !== 1'b1) busy_ok = 0;
        if (bus.w_ready !== !INT_W) wr_ok = 0;
      end
    end
    r_lat = cyc + 1;
    check("done_seen", got_done, 1'b1);
    check("busy_in_round", busy_ok, 1'b1);
    check("w_ready_in_round", wr_ok, 1'b1);
    @(posedge clk);
    #1;
    exp_block = (exp_block == 2'd1) ? 2'd2 : 2'd1;
    check("done_one_cycle", bus.done, 1'b0);
    check("idle_busy", bus.busy, 1'b0);
    check("work_out_hold", bus.work_out, r_res);
    check("block_after_done", bus.Block, exp_block);
  endtask

  initial begin
    bit nm_seq [4];
    logic [255:0] hin;
    int dones;
    nm_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
    bus.start = 1'b0; bus.new_msg = 1'b0; bus.h_in = '0; bus.msg_block = '0;
    bus.w_valid = 1'b0; bus.w_data = '0;
    for (int i = 0; i < 16; i++) tb_m[i] = '0;
    exp_block = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_work_out", bus.work_out, '0);
    check("rst_block", bus.Block, 2'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_w_ready", bus.w_ready, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // "abc"
    tb_m[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) tb_m[i] = '0;
    tb_m[15] = 32'h00000018;
    build_schedule();
    run_block(1'b1, rand256(), 0, -1, -1);
    check("abc_latency", r_lat, 65);
    check("abc_a", r_res[255:224], 32'h506E3058);
    check("abc_H0", r_res[255:224] + 32'h6a09e667, 32'hBA7816BF);
    check("abc_model", r_res, ref_compress(IV));
    check("abc_beats", r_beats, INT_W ? 0 : 64);
    abc_res = r_res;

    // Same block with a 5-cycle gap after round 10
    run_block(1'b1, rand256(), 1, -1, -1);
    check("stall_latency", r_lat, INT_W ? 65 : 70);
    check("stall_result", r_res, abc_res);

    // Empty message
    tb_m[0] = 32'h80000000;
    for (int i = 1; i < 16; i++) tb_m[i] = '0;
    build_schedule();
    run_block(1'b1, rand256(), 0, -1, -1);
    check("empty_latency", r_lat, 65);
    check("empty_a", r_res[255:224], 32'h79A6DDDB);
    check("empty_model", r_res, ref_compress(IV));

    // Block sequence after a fresh reset, random messages and random stalls
    @(negedge clk) rst_n = 1'b0;
    #1 check("rst2_block", bus.Block, 2'd0);
    exp_block = 2'd0;
    @(negedge clk) rst_n = 1'b1;
    for (int b = 0; b < 4; b++) begin
      random_msg();
      hin = rand256();
      run_block(nm_seq[b], hin, 2, -1, -1);
      check("seq_latency", r_lat, INT_W ? 65 : 65 + r_stalls);
      check("seq_result", r_res, ref_compress(nm_seq[b] ? IV : hin));
      check("seq_beats", r_beats, INT_W ? 0 : 64);
    end
    check("seq_final_block", bus.Block, 2'd1);

    // start pulsed mid-compression must be ignored
    random_msg();
    hin = rand256();
    run_block(1'b0, hin, 0, 20, -1);
    check("busy_start_latency", r_lat, 65);
    check("busy_start_result", r_res, ref_compress(hin));
    check("busy_start_beats", r_beats, INT_W ? 0 : 64);
    dones = 0;
    bus.w_valid = 1'b1;
    repeat (70) begin
      @(posedge clk);
      #1 if (bus.done === 1'b1) dones++;
    end
    check("busy_start_extra_done", dones, 0);

    // Reset asserted at round 30
    random_msg();
    run_block(1'b0, rand256(), 0, -1, 30);
    check("pre_abort_block", bus.Block, exp_block);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_w_ready", bus.w_ready, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_work_out", bus.work_out, '0);
    check("abort_block", bus.Block, 2'd0);
    exp_block = 2'd0;
    @(negedge clk) rst_n = 1'b1;
    bus.w_valid = 1'b1;
    dones = 0;
    repeat (80) begin
      @(posedge clk);
      #1 if (bus.done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_idle", bus.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
